ps2_tx: RTL

- PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the console core to the keyboard on the shared open-collector ps2Clk/ps2Data lines.
- It is the opposite direction of the existing ps2 receiver and sits beside it in the top level.
- The top level ties each line low when the matching *_oe output is 1, and releases the line (Z) otherwise.
- While the transmitter is busy, the receiver ignores the bus.

---
 rtl/ps2_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-collector clock/data enables.
// Build macro PS2_TX_RETRY_EN: a failed send is retried up to two more times before tx_error.
module ps2_tx #(
  parameter int CLK_HZ         = 25000000,
  parameter int INHIBIT_US     = 100,
  parameter int TIMEOUT_US     = 15000,
  parameter int BIT_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);
  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int INH_CYC    = CYC_PER_US * INHIBIT_US;
  localparam int TO_CYC     = CYC_PER_US * TIMEOUT_US;
  localparam int BIT_CYC    = CYC_PER_US * BIT_TIMEOUT_US;
  localparam int MAX_A      = (INH_CYC > BIT_CYC) ? INH_CYC : BIT_CYC;
  localparam int MAX_CYC    = (TO_CYC > MAX_A) ? TO_CYC : MAX_A;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] INHIBIT   = 4'd1;
  localparam logic [3:0] START     = 4'd2;
  localparam logic [3:0] REQ       = 4'd3;
  localparam logic [3:0] SEND      = 4'd4;
  localparam logic [3:0] ACK       = 4'd5;
  localparam logic [3:0] WAIT_IDLE = 4'd6;
  localparam logic [3:0] DONE      = 4'd7;
  localparam logic [3:0] FAIL      = 4'd8;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_NACK  = 2'd1;
  localparam logic [1:0] ERR_START = 2'd2;
  localparam logic [1:0] ERR_BIT   = 2'd3;

  function automatic logic majority(input logic [3:0] hist, input logic prev);
    int ones;
    ones = $countones(hist);
    if (ones >= 3) return 1'b1;
    if (ones <= 1) return 1'b0;
    return prev;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             clk_sync_p0, clk_sync_p1, data_sync_p0, data_sync_p1;
  logic [3:0]       clk_hist_p2, data_hist_p2;
  logic             clk_f, data_f, clk_f_d, clk_fall;
  logic [3:0]       state;
  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] to_cnt, gap_cnt;
  logic             data_oe_q;
  logic             fail_now;
  logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt;
`endif

  // p0/p1: two-flop synchronizers; p2: 4-sample history feeding the hysteretic majority filter
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
      clk_hist_p2  <= 4'hF;
      data_hist_p2 <= 4'hF;
      clk_f        <= 1'b1;
      data_f       <= 1'b1;
      clk_f_d      <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk_i;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= ps2_data_i;
      data_sync_p1 <= data_sync_p0;
      clk_hist_p2  <= {clk_hist_p2[2:0], clk_sync_p1};
      data_hist_p2 <= {data_hist_p2[2:0], data_sync_p1};
      clk_f        <= majority(clk_hist_p2, clk_f);
      data_f       <= majority(data_hist_p2, data_f);
      clk_f_d      <= clk_f;
    end
  end

  assign clk_fall = clk_f_d & ~clk_f;

  // Timeouts are checked ahead of the edge handling so an expiry beats a coincident edge.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    if (state == REQ || state == SEND || state == ACK) begin
      if (to_cnt == TO_LAST) begin
        fail_now  = 1'b1;
        fail_code = ERR_START;
      end else if (state != REQ && gap_cnt == BIT_LAST) begin
        fail_now  = 1'b1;
        fail_code = ERR_BIT;
      end else if (state == ACK && clk_fall && data_f) begin
        fail_now  = 1'b1;
        fail_code = ERR_NACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && tx_valid) frame <= {1'b1, ~^tx_data, tx_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data_oe_q <= 1'b0;
      err_code  <= ERR_NONE;
      bit_idx   <= 4'd0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else if (fail_now) begin
      err_code  <= fail_code;
      data_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry_cnt <= retry_cnt + 1'b1;
        to_cnt    <= '0;
        state     <= INHIBIT;
      end else begin
        state <= FAIL;
      end
`else
      state <= FAIL;
`endif
    end else begin
      case (state)
        IDLE: begin
          data_oe_q <= 1'b0;
          if (tx_valid) begin
            err_code <= ERR_NONE;
            to_cnt   <= '0;
            state    <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_cnt <= 2'd0;
`endif
          end
        end
        INHIBIT: begin
          if (to_cnt == INH_LAST) begin
            data_oe_q <= 1'b1;
            state     <= START;
          end else begin
            to_cnt <= sat_inc(to_cnt);
          end
        end
        START: begin
          to_cnt  <= '0;
          bit_idx <= 4'd0;
          state   <= REQ;
        end
        REQ: begin
          to_cnt <= sat_inc(to_cnt);
          if (clk_fall) begin
            data_oe_q <= ~frame[0];
            bit_idx   <= 4'd1;
            gap_cnt   <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          to_cnt <= sat_inc(to_cnt);
          if (clk_fall) begin
            data_oe_q <= ~frame[bit_idx];
            bit_idx   <= bit_idx + 1'b1;
            gap_cnt   <= '0;
            if (bit_idx == 4'd9) state <= ACK;
          end else begin
            gap_cnt <= sat_inc(gap_cnt);
          end
        end
        ACK: begin
          to_cnt <= sat_inc(to_cnt);
          if (clk_fall) begin
            gap_cnt <= '0;
            state   <= WAIT_IDLE;
          end else begin
            gap_cnt <= sat_inc(gap_cnt);
          end
        end
        WAIT_IDLE: begin
          if ((clk_f && data_f) || gap_cnt == BIT_LAST) state <= DONE;
          else gap_cnt <= sat_inc(gap_cnt);
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign tx_done     = (state == DONE);
  assign tx_error    = (state == FAIL);
endmodule
